vga_frame_source: RTL
=====================

Name: vga_frame_source

Overview:
- Synthesizable VGA stream producer for 1024x768@60 (pclk 65 MHz); the transmit end of the VGA interface that the image-capture bench consumes.
- Generates horizontal/vertical timing and issues pixel read addresses to a synchronous frame ROM/BRAM with 1-cycle read latency.
- Drives registered hs, vs, r, g, b, with sync aligned to pixel data.
- Sits between the clock wizard output and the FPGA VGA pins inside top_fpga.

Parameters:
- HOR_ACTIVE, 1024, visible pixels per line
- HOR_SYNC_START, 1048, hcount at which hs asserts
- HOR_SYNC_STOP, 1184, hcount at which hs deasserts
- HOR_TOTAL, 1344, clocks per line
- VER_ACTIVE, 768, visible lines
- VER_SYNC_START, 771, vcount at which vs asserts
- VER_SYNC_STOP, 777, vcount at which vs deasserts
- VER_TOTAL, 806, lines per frame
- ADDR_W, 20, frame memory address width

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- addr  out  ADDR_W  frame memory read address
- rgb_in  in  12  memory data {r,g,b}; valid 1 clk after addr
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- r, g, b  out  4 each  pixel colour, forced 0 in blanking
- frame_start  out  1  one-clk pulse, aligned with output pixel (0,0)

Behaviour:
- Stage 0 counters: hcount, vcount, 11 bits each, registered.
  - hcount increments every clk and wraps HOR_TOTAL-1 -> 0.
  - On that wrap, vcount increments and wraps VER_TOTAL-1 -> 0.
- Stage 0 decode:
  - active = (hcount < HOR_ACTIVE) && (vcount < VER_ACTIVE).
  - hs_raw asserted for HOR_SYNC_START <= hcount < HOR_SYNC_STOP.
  - vs_raw asserted for VER_SYNC_START <= vcount < VER_SYNC_STOP.
- Address:
  - addr registered in stage 1 as {vcount[9:0], hcount[9:0]} when active.
  - addr holds its last value when not active; no read is issued outside the active area.
- Stage 2:
  - r/g/b = rgb_in when delayed active = 1, else 0.
  - hs, vs, frame_start come from stage-0 values delayed 2 clks.
  - Pixel (h,v) with its syncs appears on the outputs exactly 2 clks after the counters equal (h,v).
- frame_start asserts on the output cycle of pixel (0,0).
- All outputs are registered; no combinational path from rgb_in to the pins except through the stage-2 register.
- Reset (asynchronous, any time, including mid-line):
  - hcount = vcount = 0, addr = 0, r = g = b = 0.
  - hs = vs = 1 (inactive), frame_start = 0.
  - Pipeline delay registers cleared to the inactive/blank state.
- First clk after rst deasserts: counters leave (0,0). First visible output pixel and frame_start appear 2 clks later.
- Boundary cases:
  - Line end (hcount = 1343) and frame end (vcount = 805, hcount = 1343) wrap in the same cycle.
  - No extra or missing clocks per line or frame.
  - Frame period = 1344*806 = 1083264 clks.
- Widths: counter compares unsigned at 11 bits. Parameters are required to satisfy ACTIVE < SYNC_START < SYNC_STOP <= TOTAL <= 2047.

Optional Feature:
- Macro TEST_PATTERN_EN.
- Defined:
  - rgb_in is ignored.
  - Active pixels show 8 vertical colour bars of width HOR_ACTIVE/8, selected by delayed hcount[9:7]. Bars 0..7 = white, yellow, cyan, green, magenta, red, blue, black (4'hF/4'h0 per channel).
  - A 1-pixel white border is drawn at h = 0, h = 1023, v = 0, v = 767.
  - Pipeline latency is unchanged (2 clks).
- Not defined: colours come from rgb_in as above.
- addr behaves identically in both builds.

Test Plan:
1. Reset 2000 ns, release; drive rgb_in = 12'hABC constant.
   - frame_start pulses once per 1083264 clks.
   - First pulse comes 2 clks after reset release, with r/g/b = A/B/C.
2. Line timing, measured on hs:
   - Low for 136 clks, period 1344 clks.
   - r/g/b nonzero for exactly 1024 clks per active line.
   - Zero for lines 768..805.
3. Frame timing, measured on vs:
   - Low for 6 lines (8064 clks), period 806 lines.
   - First negedge vs occurs 771*1344 + 2 clks after reset release.
4. Address/latency check with a bench ROM returning data = addr[11:0] one clk later:
   - Output pixel (h = 5, v = 3) shows {r,g,b} = 12'hC05.
   - addr = {10'd3, 10'd5} is issued 1 clk before the counters reach (6,3).
5. Asynchronous reset at hcount = 700, vcount = 400:
   - Same cycle, without a clock edge: hs = vs = 1, rgb = 0.
   - After release, timing restarts from (0,0) exactly as in scenario 1.
6. TEST_PATTERN_EN build:
   - Output pixel (130, 10) = F/F/0 (yellow).
   - (0, 10) = F/F/F (border).
   - (1000, 767) = F/F/F (border).
   - (1000, 10) = 0/0/0 (black).

Source files
------------

// File: rtl/vga_frame_source.sv
// 1024x768@60 VGA stream source: timing counters, frame-memory addressing and a 2-clk registered pixel pipeline.
// Define TEST_PATTERN_EN to replace rgb_in with internal colour bars and a 1-pixel white border.
module vga_frame_source #(
   parameter int HOR_ACTIVE     = 1024,
   parameter int HOR_SYNC_START = 1048,
   parameter int HOR_SYNC_STOP  = 1184,
   parameter int HOR_TOTAL      = 1344,
   parameter int VER_ACTIVE     = 768,
   parameter int VER_SYNC_START = 771,
   parameter int VER_SYNC_STOP  = 777,
   parameter int VER_TOTAL      = 806,
   parameter int ADDR_W         = 20
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] addr,
   input  logic [11:0]       rgb_in,
   output logic              hs,
   output logic              vs,
   output logic [3:0]        r,
   output logic [3:0]        g,
   output logic [3:0]        b,
   output logic              frame_start
);

   localparam logic [10:0] H_ACT  = 11'(HOR_ACTIVE);
   localparam logic [10:0] H_SS   = 11'(HOR_SYNC_START);
   localparam logic [10:0] H_SP   = 11'(HOR_SYNC_STOP);
   localparam logic [10:0] H_LAST = 11'(HOR_TOTAL - 1);
   localparam logic [10:0] V_ACT  = 11'(VER_ACTIVE);
   localparam logic [10:0] V_SS   = 11'(VER_SYNC_START);
   localparam logic [10:0] V_SP   = 11'(VER_SYNC_STOP);
   localparam logic [10:0] V_LAST = 11'(VER_TOTAL - 1);

   logic [10:0] hcount, vcount;
   logic [10:0] hcount_nxt, vcount_nxt;
   logic        active, active_nxt, hs_raw, vs_raw, first_px;
   logic        active_d, hs_d, vs_d, first_d;
   logic [11:0] pixel;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      hcount_nxt = hcount + 11'd1;
      vcount_nxt = vcount;
      if (hcount == H_LAST) begin
         hcount_nxt = '0;
         vcount_nxt = (vcount == V_LAST) ? '0 : vcount + 11'd1;
      end
   end

   assign active     = (hcount < H_ACT) && (vcount < V_ACT);
   assign active_nxt = (hcount_nxt < H_ACT) && (vcount_nxt < V_ACT);
   assign hs_raw     = (hcount >= H_SS) && (hcount < H_SP);
   assign vs_raw     = (vcount >= V_SS) && (vcount < V_SP);
   assign first_px   = (hcount == '0) && (vcount == '0);

   // addr is loaded from the next counter value so the 1-clk memory read lands in step with stage 1.
   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount <= '0;
         vcount <= '0;
         addr   <= '0;
      end else begin
         hcount <= hcount_nxt;
         vcount <= vcount_nxt;
         if (active_nxt)
            addr <= ADDR_W'({vcount_nxt[9:0], hcount_nxt[9:0]});
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_d <= 1'b0;
         hs_d     <= 1'b0;
         vs_d     <= 1'b0;
         first_d  <= 1'b0;
      end else begin
         active_d <= active;
         hs_d     <= hs_raw;
         vs_d     <= vs_raw;
         first_d  <= first_px;
      end
   end

`ifdef TEST_PATTERN_EN
   logic [10:0] hcount_d, vcount_d;
   logic        unused_rgb;

   assign unused_rgb = ^rgb_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount_d <= '0;
         vcount_d <= '0;
      end else begin
         hcount_d <= hcount;
         vcount_d <= vcount;
      end
   end

   always_comb begin
      pixel = 12'h000;
      if (hcount_d == '0 || hcount_d == H_ACT - 11'd1 || vcount_d == '0 || vcount_d == V_ACT - 11'd1)
         pixel = 12'hFFF;
      else
         case (hcount_d[9:7])
            3'd0:    pixel = 12'hFFF;
            3'd1:    pixel = 12'hFF0;
            3'd2:    pixel = 12'h0FF;
            3'd3:    pixel = 12'h0F0;
            3'd4:    pixel = 12'hF0F;
            3'd5:    pixel = 12'hF00;
            3'd6:    pixel = 12'h00F;
            default: pixel = 12'h000;
         endcase
   end
`else
   assign pixel = rgb_in;
`endif

   // Output stage: syncs are active-low on the pins, colour is blanked outside the active area.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r           <= '0;
         g           <= '0;
         b           <= '0;
         hs          <= 1'b1;
         vs          <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         {r, g, b}   <= active_d ? pixel : 12'h000;
         hs          <= ~hs_d;
         vs          <= ~vs_d;
         frame_start <= first_d;
      end
   end

endmodule
